// File: rtl/mpt_pkg.sv
// Shared MPT walker types: transaction layout, ROB id, issue-stage FSM states.
package mpt_pkg;

  localparam int ROB_ID_WIDTH = 5;
  localparam int SPA_WIDTH    = 27;

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_size_t;

  typedef struct packed {
    logic [SPA_WIDTH-1:0] spa;
    rob_id_size_t         id;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    ISSUE_IDLE     = 2'd0,
    ISSUE_REQ_ID   = 2'd1,
    ISSUE_WAIT_ID  = 2'd2,
    ISSUE_DISPATCH = 2'd3
  } issue_state_e;

  localparam rob_id_size_t ROB_INVALID_ID = '1;

endpackage

// File: rtl/pipeline_register.sv
// One-entry valid/ready register; a full slot refills on the same edge it drains.
// Latency 1 cycle; i_ready low holds o_valid/o_data stable.
module pipeline_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: frontend -> retire ID request -> ID-tagged dispatch, bounded by ROB occupancy.
// Optional macro ISSUE_STAGE_ID_CHECK_EN validates retire responses and re-requests on reject.
module issue_stage
  import mpt_pkg::*;
#(
  parameter int PIPELINE_DATA_WIDTH  = 32,
  parameter int REORDER_BUFFER_DEPTH = 32,
  parameter bit PIPELINE_PASSTHROUGH = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    frontend_slave_valid,
  output logic                                    frontend_slave_ready,
  input  logic [PIPELINE_DATA_WIDTH-1:0]          frontend_slave_data,
  output logic                                    retire_master_valid,
  input  logic                                    retire_master_ready,
  output logic [PIPELINE_DATA_WIDTH-1:0]          retire_master_data,
  input  logic                                    retire_slave_valid,
  output logic                                    retire_slave_ready,
  input  logic [PIPELINE_DATA_WIDTH-1:0]          retire_slave_data,
  output logic                                    dispatch_master_valid,
  input  logic                                    dispatch_master_ready,
  output logic [PIPELINE_DATA_WIDTH-1:0]          dispatch_master_data,
  input  logic                                    commit_done_i,
  output logic [$clog2(REORDER_BUFFER_DEPTH):0]   outstanding_o,
  output logic                                    id_error_o
);

  localparam int                CNT_W   = $clog2(REORDER_BUFFER_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(REORDER_BUFFER_DEPTH);

  issue_state_e      r_state;
  mptw_transaction_t r_req_q;
  mptw_transaction_t r_rsp_q;
  logic [CNT_W-1:0]  r_outstanding;

  mptw_transaction_t w_fe;
  mptw_transaction_t w_rsp;
  logic              w_disp_in_valid;
  logic              w_disp_in_ready;
  logic              w_disp_pending;
  logic              w_disp_hs;
  logic              w_commit_dec;
  logic              w_below_limit;
  logic              w_reject;

  assign w_fe  = frontend_slave_data;
  assign w_rsp = retire_slave_data;

  // A transaction parked in the dispatch register is not yet counted, so reserve its slot.
  assign w_below_limit = (r_outstanding + {{(CNT_W-1){1'b0}}, w_disp_pending}) < DEPTH_C;

  assign frontend_slave_ready = !rst_i && (r_state == ISSUE_IDLE) && w_below_limit;
  assign retire_slave_ready   = !rst_i && (r_state == ISSUE_WAIT_ID);
  assign retire_master_valid  = (r_state == ISSUE_REQ_ID);
  assign retire_master_data   = r_req_q;
  assign w_disp_in_valid      = (r_state == ISSUE_DISPATCH);

`ifdef ISSUE_STAGE_ID_CHECK_EN
  logic r_id_error;

  assign w_reject = (w_rsp.id == ROB_INVALID_ID)
                 || (32'(w_rsp.id) >= REORDER_BUFFER_DEPTH)
                 || (w_rsp.spa != r_req_q.spa);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_id_error <= 1'b0;
    else       r_id_error <= (r_state == ISSUE_WAIT_ID) && retire_slave_valid && w_reject;
  end

  assign id_error_o = r_id_error;
`else
  assign w_reject   = 1'b0;
  assign id_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ISSUE_IDLE;
      r_req_q <= '0;
      r_rsp_q <= '0;
    end else begin
      case (r_state)
        ISSUE_IDLE: begin
          if (frontend_slave_valid && frontend_slave_ready) begin
            r_req_q    <= w_fe;
            r_req_q.id <= ROB_INVALID_ID;
            r_state    <= ISSUE_REQ_ID;
          end
        end
        ISSUE_REQ_ID: begin
          if (retire_master_ready) r_state <= ISSUE_WAIT_ID;
        end
        ISSUE_WAIT_ID: begin
          if (retire_slave_valid) begin
            if (w_reject) begin
              r_state <= ISSUE_REQ_ID;
            end else begin
              r_rsp_q <= w_rsp;
              r_state <= ISSUE_DISPATCH;
            end
          end
        end
        ISSUE_DISPATCH: begin
          if (w_disp_in_ready) r_state <= ISSUE_IDLE;
        end
        default: r_state <= ISSUE_IDLE;
      endcase
    end
  end

  generate
    if (PIPELINE_PASSTHROUGH) begin : g_pass
      assign dispatch_master_valid = w_disp_in_valid;
      assign dispatch_master_data  = r_rsp_q;
      assign w_disp_in_ready       = dispatch_master_ready;
      assign w_disp_pending        = 1'b0;
    end else begin : g_reg
      pipeline_register #(
        .WIDTH(PIPELINE_DATA_WIDTH)
      ) u_dispatch_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_disp_in_valid),
        .o_ready (w_disp_in_ready),
        .i_data  (r_rsp_q),
        .o_valid (dispatch_master_valid),
        .i_ready (dispatch_master_ready),
        .o_data  (dispatch_master_data)
      );
      assign w_disp_pending = dispatch_master_valid;
    end
  endgenerate

  assign w_disp_hs    = dispatch_master_valid && dispatch_master_ready;
  assign w_commit_dec = commit_done_i && (r_outstanding != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_disp_hs, w_commit_dec})
        2'b10:   if (r_outstanding != DEPTH_C) r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign outstanding_o = r_outstanding;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage at ROB depth 4: retire-stage responder, dispatch scoreboard, directed checks.
module tb_issue_stage;
  import mpt_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          frontend_slave_valid;
  logic          frontend_slave_ready;
  logic [DW-1:0] frontend_slave_data;
  logic          retire_master_valid;
  logic          retire_master_ready;
  logic [DW-1:0] retire_master_data;
  logic          retire_slave_valid;
  logic          retire_slave_ready;
  logic [DW-1:0] retire_slave_data;
  logic          dispatch_master_valid;
  logic          dispatch_master_ready;
  logic [DW-1:0] dispatch_master_data;
  logic          commit_done_i;
  logic [2:0]    outstanding_o;
  logic          id_error_o;

  issue_stage #(
    .PIPELINE_DATA_WIDTH(DW),
    .REORDER_BUFFER_DEPTH(DEPTH),
    .PIPELINE_PASSTHROUGH(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .frontend_slave_valid(frontend_slave_valid), .frontend_slave_ready(frontend_slave_ready),
    .frontend_slave_data(frontend_slave_data),
    .retire_master_valid(retire_master_valid), .retire_master_ready(retire_master_ready),
    .retire_master_data(retire_master_data),
    .retire_slave_valid(retire_slave_valid), .retire_slave_ready(retire_slave_ready),
    .retire_slave_data(retire_slave_data),
    .dispatch_master_valid(dispatch_master_valid), .dispatch_master_ready(dispatch_master_ready),
    .dispatch_master_data(dispatch_master_data),
    .commit_done_i(commit_done_i), .outstanding_o(outstanding_o), .id_error_o(id_error_o)
  );

  always #5 clk_i = ~clk_i;

  int           total = 0;
  int           bad   = 0;
  logic [31:0]  exp_q[$];
  rob_id_size_t id_q[$];
  int           rsp_delay = 0;
  int           rm_cnt = 0;
  int           err_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Retire stage model: registers its reply one cycle (plus rsp_delay) after the ID request.
  initial begin
    logic rm_hs, rs_hs, rst_s, pend;
    int cnt;
    mptw_transaction_t t, r;
    retire_slave_valid = 1'b0;
    retire_slave_data  = '0;
    pend = 1'b0;
    cnt  = 0;
    r    = '0;
    forever begin
      @(negedge clk_i);
      rst_s = rst_i;
      rm_hs = retire_master_valid && retire_master_ready;
      rs_hs = retire_slave_valid && retire_slave_ready;
      t     = retire_master_data;
      @(posedge clk_i); #1;
      if (rst_s) begin
        pend = 1'b0;
        retire_slave_valid = 1'b0;
      end else begin
        if (rs_hs) retire_slave_valid = 1'b0;
        if (rm_hs) begin
          rm_cnt++;
          pend  = 1'b1;
          cnt   = rsp_delay;
          r.spa = t.spa;
          if (id_q.size() == 0) begin
            chk("retire_id_available", 32'(id_q.size()), 32'd1);
            r.id = '0;
          end else begin
            r.id = id_q.pop_front();
          end
        end
        if (pend) begin
          if (cnt == 0) begin
            retire_slave_valid = 1'b1;
            retire_slave_data  = r;
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Dispatch monitor: scoreboard pop on handshake, stability while stalled.
  initial begin
    logic pv, pr;
    logic [31:0] pd;
    pv = 1'b0; pr = 1'b1; pd = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("disp_hold_valid", 32'(dispatch_master_valid), 32'd1);
          chk("disp_hold_data", dispatch_master_data, pd);
        end
        if (dispatch_master_valid && dispatch_master_ready) begin
          if (exp_q.size() == 0) chk("disp_unexpected", dispatch_master_data, 32'hxxxx_xxxx);
          else chk("disp_data", dispatch_master_data, exp_q.pop_front());
        end
        if (id_error_o) err_pulses++;
        pv = dispatch_master_valid;
        pr = dispatch_master_ready;
        pd = dispatch_master_data;
      end
    end
  end

  task automatic send(input logic [26:0] spa);
    bit ok;
    ok = 1'b0;
    frontend_slave_valid = 1'b1;
    frontend_slave_data  = {spa, 5'h0A};
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (frontend_slave_ready) ok = 1'b1;
    end
    @(posedge clk_i); #1;
    frontend_slave_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic expect_txn(input logic [26:0] spa, input rob_id_size_t id);
    exp_q.push_back({spa, id});
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
  endtask

  task automatic wait_disp_valid;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      seen = dispatch_master_valid;
    end
    chk("disp_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic commit;
    commit_done_i = 1'b1;
    @(posedge clk_i); #1;
    commit_done_i = 1'b0;
  endtask

  initial begin
    int stall_viol;
    rst_i = 1'b1;
    frontend_slave_valid = 1'b0;
    frontend_slave_data  = '0;
    retire_master_ready  = 1'b1;
    dispatch_master_ready = 1'b1;
    commit_done_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_fe_ready", 32'(frontend_slave_ready), 32'd0);
    chk("rst_rs_ready", 32'(retire_slave_ready), 32'd0);
    chk("rst_rm_valid", 32'(retire_master_valid), 32'd0);
    chk("rst_disp_valid", 32'(dispatch_master_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_id_error", 32'(id_error_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_fe_ready", 32'(frontend_slave_ready), 32'd1);
    @(posedge clk_i); #1;

    // Single request, latency check
    id_q.push_back(5'd0);
    expect_txn(27'h1000, 5'd0);
    send(27'h1000);
    repeat (3) @(negedge clk_i);
    chk("lat_cycle3_valid", 32'(dispatch_master_valid), 32'd0);
    @(negedge clk_i);
    chk("lat_cycle4_valid", 32'(dispatch_master_valid), 32'd1);
    @(negedge clk_i);
    chk("single_outstanding", 32'(outstanding_o), 32'd1);
    @(posedge clk_i); #1;
    commit();
    @(negedge clk_i);
    chk("commit_to_zero", 32'(outstanding_o), 32'd0);
    @(posedge clk_i); #1;

    // Four back-to-back, then full stall
    for (int i = 0; i < 4; i++) begin
      id_q.push_back(rob_id_size_t'(i));
      expect_txn(27'h2000 + 27'(i), rob_id_size_t'(i));
      send(27'h2000 + 27'(i));
    end
    drain();
    chk("full_outstanding", 32'(outstanding_o), 32'd4);
    @(posedge clk_i); #1;
    frontend_slave_valid = 1'b1;
    frontend_slave_data  = {27'h2004, 5'h0A};
    id_q.push_back(5'd0);
    expect_txn(27'h2004, 5'd0);
    stall_viol = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (frontend_slave_ready) stall_viol++;
    end
    chk("full_stall", 32'(stall_viol), 32'd0);
    @(posedge clk_i); #1;
    commit();
    @(negedge clk_i);
    chk("release_outstanding", 32'(outstanding_o), 32'd3);
    chk("release_fe_ready", 32'(frontend_slave_ready), 32'd1);
    @(posedge clk_i); #1;
    frontend_slave_valid = 1'b0;
    drain();
    chk("refill_outstanding", 32'(outstanding_o), 32'd4);
    @(posedge clk_i); #1;
    repeat (4) commit();
    @(negedge clk_i);
    chk("commit_all", 32'(outstanding_o), 32'd0);
    @(posedge clk_i); #1;
    commit();
    @(negedge clk_i);
    chk("commit_at_zero", 32'(outstanding_o), 32'd0);
    @(posedge clk_i); #1;

    // Dispatch backpressure
    dispatch_master_ready = 1'b0;
    id_q.push_back(5'd1);
    expect_txn(27'h3000, 5'd1);
    send(27'h3000);
    wait_disp_valid();
    repeat (5) @(negedge clk_i);
    chk("stall_outstanding", 32'(outstanding_o), 32'd0);
    @(posedge clk_i); #1;
    dispatch_master_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("release_inc", 32'(outstanding_o), 32'd1);
    repeat (3) @(negedge clk_i);
    chk("single_inc", 32'(outstanding_o), 32'd1);
    @(posedge clk_i); #1;

    // Commit coinciding with dispatch at count 2
    id_q.push_back(5'd2);
    expect_txn(27'h4000, 5'd2);
    send(27'h4000);
    drain();
    chk("pre_coincide", 32'(outstanding_o), 32'd2);
    @(posedge clk_i); #1;
    dispatch_master_ready = 1'b0;
    id_q.push_back(5'd3);
    expect_txn(27'h4001, 5'd3);
    send(27'h4001);
    wait_disp_valid();
    @(posedge clk_i); #1;
    dispatch_master_ready = 1'b1;
    commit();
    @(negedge clk_i);
    chk("coincide_count", 32'(outstanding_o), 32'd2);
    @(posedge clk_i); #1;

    // Bad retire id
    err_pulses = 0;
    rm_cnt = 0;
`ifdef ISSUE_STAGE_ID_CHECK_EN
    id_q.push_back(5'h1F);
    id_q.push_back(5'd1);
    expect_txn(27'h5000, 5'd1);
    send(27'h5000);
    drain();
    chk("id_err_pulses", 32'(err_pulses), 32'd1);
    chk("id_err_rerequest", 32'(rm_cnt), 32'd2);
`else
    id_q.push_back(5'h1F);
    expect_txn(27'h5000, 5'h1F);
    send(27'h5000);
    drain();
    chk("id_err_pulses", 32'(err_pulses), 32'd0);
    chk("id_err_rerequest", 32'(rm_cnt), 32'd1);
`endif
    chk("bad_id_outstanding", 32'(outstanding_o), 32'd3);
    @(posedge clk_i); #1;

    // Reset while waiting for the ID
    rsp_delay = 4;
    id_q.push_back(5'd0);
    expect_txn(27'h6000, 5'd0);
    send(27'h6000);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("in_wait_id", 32'(retire_slave_ready), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_rs_ready", 32'(retire_slave_ready), 32'd0);
    chk("midrst_fe_ready", 32'(frontend_slave_ready), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    id_q.delete();
    rsp_delay = 0;
    @(negedge clk_i);
    chk("midrst_rm_valid", 32'(retire_master_valid), 32'd0);
    chk("midrst_disp_valid", 32'(dispatch_master_valid), 32'd0);
    chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
    chk("midrst_fe_ready", 32'(frontend_slave_ready), 32'd1);
    @(posedge clk_i); #1;

    // Normal operation resumes
    id_q.push_back(5'd2);
    expect_txn(27'h7000, 5'd2);
    send(27'h7000);
    drain();
    chk("resume_outstanding", 32'(outstanding_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
